// File: rtl/systolic_scheduler.sv
// Purpose: sequences one output-stationary NxN MAC pass (clear, skewed feed, drain, row unload).
// Latency: start to done_o = 1 + K + (2N-1) + N + 1 cycles when unstalled (N=4, K=3 -> 16).
// Backpressure: stall_i freezes FEED/DRAIN/UNLOAD and masks all enables; optional PERF_CNT_EN adds perf counters.
module systolic_scheduler #(
  parameter int N      = 4,
  parameter int K_W    = 8,
  parameter int ADDR_W = 8,
  localparam int RW    = $clog2(N)
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [K_W-1:0]    k_len_i,
  input  logic              stall_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              acc_clr_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [N-1:0]      row_en_o,
  output logic [N-1:0]      col_en_o,
  output logic              result_valid_o,
  output logic [RW-1:0]     result_row_o
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]       perf_busy_o,
  output logic [31:0]       perf_stall_o
`endif
);

  localparam int DW = $clog2(2 * N);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_FEED   = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_UNLOAD = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]     state;
  logic [K_W-1:0] k_len;
  logic [K_W-1:0] k;
  logic [DW-1:0]  dcnt;
  logic [RW-1:0]  r;
  logic [N-1:0]   skew;
  logic           stall_eff;
  logic           feed_rd;
  logic           accept;

  // Stall only has meaning while the array is moving data.
  assign stall_eff = stall_i && (state == S_FEED || state == S_DRAIN || state == S_UNLOAD);
  assign feed_rd   = (state == S_FEED) && !stall_eff;
  assign accept    = (state == S_IDLE) && start_i;

  assign ready_o        = (state == S_IDLE);
  assign busy_o         = (state != S_IDLE);
  assign done_o         = (state == S_DONE);
  assign acc_clr_o      = (state == S_CLEAR);
  assign rd_en_o        = feed_rd;
  assign rd_addr_o      = ADDR_W'(k);
  assign row_en_o       = stall_eff ? '0 : skew;
  assign col_en_o       = stall_eff ? '0 : skew;
  assign result_valid_o = (state == S_UNLOAD) && !stall_eff;
  assign result_row_o   = r;

  // Main sequencer: state plus the read, drain and unload counters.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state <= S_IDLE;
      k_len <= '0;
      k     <= '0;
      dcnt  <= '0;
      r     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            k <= '0;
            r <= '0;
            // A zero-length pass has nothing to accumulate: report completion at once.
            if (k_len_i != '0) begin
              k_len <= k_len_i;
              state <= S_CLEAR;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_CLEAR: state <= S_FEED;
        S_FEED: begin
          if (!stall_eff) begin
            if (k == k_len - 1'b1) begin
              dcnt  <= '0;
              state <= S_DRAIN;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (!stall_eff) begin
            if (dcnt == DW'(2 * N - 2)) begin
              r     <= '0;
              state <= S_UNLOAD;
            end else begin
              dcnt <= dcnt + 1'b1;
            end
          end
        end
        S_UNLOAD: begin
          if (!stall_eff) begin
            if (r == RW'(N - 1)) state <= S_DONE;
            else                 r     <= r + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Skew line: lane i sees the read strobe 1+i advancing cycles later (buffer latency plus wavefront).
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i)         skew <= '0;
    else if (!stall_eff) skew <= {skew[N-2:0], feed_rd};
  end

`ifdef PERF_CNT_EN
  // Saturating busy/stall counters, restarted by each accepted start.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      perf_busy_o  <= '0;
      perf_stall_o <= '0;
    end else if (accept) begin
      perf_busy_o  <= '0;
      perf_stall_o <= '0;
    end else begin
      if (busy_o && perf_busy_o != 32'hFFFF_FFFF)     perf_busy_o  <= perf_busy_o + 1'b1;
      if (stall_eff && perf_stall_o != 32'hFFFF_FFFF) perf_stall_o <= perf_stall_o + 1'b1;
    end
  end
`endif

endmodule
